// File: rtl/digital_lock_pkg.sv
// Shared types and default timing for the keypad lock controller.
package digital_lock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_OPEN,
        ST_ERROR,
        ST_LOCKOUT
    } lock_state_t;

    localparam logic [15:0] DEF_CODE           = 16'h1234;
    localparam int unsigned DEF_MAX_FAILS      = 3;
    localparam int unsigned DEF_OPEN_CYCLES    = 50;
    localparam int unsigned DEF_ERROR_CYCLES   = 20;
    localparam int unsigned DEF_LOCKOUT_CYCLES = 200;
    localparam int unsigned DEF_BLINK_HALF     = 5;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Shared down-counter for the timed lock states; load wins, zero_c flags expiry.
module lock_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero_c
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/digital_lock_ctrl.sv
// Four-digit keypad lock: entry register, attempt check, open/error/lockout timing.
// Optional ERROR_BLINK_EN makes the error display blink during ERROR and LOCKOUT.
module digital_lock_ctrl
    import digital_lock_pkg::*;
#(
    parameter logic [15:0] CODE           = DEF_CODE,
    parameter int unsigned MAX_FAILS      = DEF_MAX_FAILS,
    parameter int unsigned OPEN_CYCLES    = DEF_OPEN_CYCLES,
    parameter int unsigned ERROR_CYCLES   = DEF_ERROR_CYCLES,
    parameter int unsigned LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter int unsigned BLINK_HALF     = DEF_BLINK_HALF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       clear,
    output logic       unlocked,
    output logic       error,
    output logic       locked_out,
    output logic [2:0] digit_cnt,
    output logic [1:0] fail_cnt
);

    localparam int unsigned TW = $clog2(max3(OPEN_CYCLES, ERROR_CYCLES, LOCKOUT_CYCLES));

    if (MAX_FAILS < 1 || MAX_FAILS > 3 || BLINK_HALF == 0 || OPEN_CYCLES < 2 ||
        ERROR_CYCLES < 2 || LOCKOUT_CYCLES < 2) begin : g_param_check
        $error("digital_lock_ctrl: parameter out of range");
    end

    lock_state_t    state, state_next;
    logic [15:0]    entry, entry_next;
    logic [2:0]     digit_cnt_next;
    logic [1:0]     fail_cnt_next;
    logic [1:0]     fail_inc;
    logic           bad, bad_next;
    logic           tmr_load;
    logic [TW-1:0]  tmr_value;
    logic           tmr_zero;
    logic           err_state;
    logic           err_level;

    lock_timer #(.W(TW)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .value  (tmr_value),
        .zero_c (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            entry     <= '0;
            digit_cnt <= '0;
            fail_cnt  <= '0;
            bad       <= 1'b0;
        end else begin
            state     <= state_next;
            entry     <= entry_next;
            digit_cnt <= digit_cnt_next;
            fail_cnt  <= fail_cnt_next;
            bad       <= bad_next;
        end
    end

    // An out-of-range key goes through CHECK with bad set so it fails like a wrong code.
    always_comb begin
        state_next     = state;
        entry_next     = entry;
        digit_cnt_next = digit_cnt;
        fail_cnt_next  = fail_cnt;
        bad_next       = bad;
        tmr_load       = 1'b0;
        tmr_value      = '0;
        fail_inc       = fail_cnt + 2'd1;
        case (state)
            ST_IDLE: begin
                if (clear) begin
                    entry_next     = '0;
                    digit_cnt_next = '0;
                end else if (digit_valid) begin
                    if (digit <= 4'd9) begin
                        entry_next     = {entry[11:0], digit};
                        digit_cnt_next = digit_cnt + 3'd1;
                        if (digit_cnt == 3'd3) begin
                            state_next = ST_CHECK;
                        end
                    end else begin
                        bad_next   = 1'b1;
                        state_next = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                entry_next     = '0;
                digit_cnt_next = '0;
                bad_next       = 1'b0;
                tmr_load       = 1'b1;
                if (!bad && entry == CODE) begin
                    fail_cnt_next = '0;
                    state_next    = ST_OPEN;
                    tmr_value     = TW'(OPEN_CYCLES - 1);
                end else begin
                    fail_cnt_next = fail_inc;
                    if (fail_inc == 2'(MAX_FAILS)) begin
                        state_next = ST_LOCKOUT;
                        tmr_value  = TW'(LOCKOUT_CYCLES - 1);
                    end else begin
                        state_next = ST_ERROR;
                        tmr_value  = TW'(ERROR_CYCLES - 1);
                    end
                end
            end
            ST_OPEN: begin
                if (clear || tmr_zero) begin
                    state_next = ST_IDLE;
                end
            end
            ST_ERROR: begin
                if (tmr_zero) begin
                    state_next = ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                if (tmr_zero) begin
                    state_next    = ST_IDLE;
                    fail_cnt_next = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign err_state = (state == ST_ERROR) || (state == ST_LOCKOUT);

`ifdef ERROR_BLINK_EN
    localparam int unsigned BW = $clog2(BLINK_HALF + 1);

    logic [BW-1:0] blink_cnt;
    logic          blink_on;
    logic          err_entry;

    assign err_entry = (state == ST_CHECK) &&
                       ((state_next == ST_ERROR) || (state_next == ST_LOCKOUT));

    // Phase restarts high on every entry into an error state.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_on  <= 1'b0;
        end else if (err_entry) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (err_state) begin
            if (blink_cnt == BW'(BLINK_HALF - 1)) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    assign err_level = err_state && blink_on;
`else
    assign err_level = err_state;
`endif

    // Display outputs are a registered decode of the current state.
    always_ff @(posedge clk) begin
        if (rst) begin
            unlocked   <= 1'b0;
            error      <= 1'b0;
            locked_out <= 1'b0;
        end else begin
            unlocked   <= (state == ST_OPEN);
            error      <= err_level;
            locked_out <= (state == ST_LOCKOUT);
        end
    end

endmodule

// File: tb/tb_digital_lock_ctrl.sv
// Scoreboard bench for digital_lock_ctrl: each attempt queues its expected outcome,
// which is popped and checked when the lock outputs respond.
module tb_digital_lock_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       digit_valid;
    logic [3:0] digit;
    logic       clear;
    logic       unlocked;
    logic       error;
    logic       locked_out;
    logic [2:0] digit_cnt;
    logic [1:0] fail_cnt;

    int unsigned cyc = 0;
    int          n_total = 0;
    int          n_bad = 0;

`ifdef ERROR_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    typedef struct {
        string       tag;
        bit          open;
        bit          lock;
        int unsigned dur;
        int unsigned t_rise;
        logic [1:0]  fail;
        logic [1:0]  fail_end;
    } exp_t;

    exp_t sb[$];

    digital_lock_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .digit_valid (digit_valid),
        .digit       (digit),
        .clear       (clear),
        .unlocked    (unlocked),
        .error       (error),
        .locked_out  (locked_out),
        .digit_cnt   (digit_cnt),
        .fail_cnt    (fail_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic bit err_exp(input bit open, input int unsigned i);
        if (open) return 1'b0;
        return !BLINK_ON || (((i / 5) % 2) == 0);
    endfunction

    task automatic send_digit(input logic [3:0] d);
        digit_valid = 1'b1;
        digit       = d;
        @(negedge clk);
        digit_valid = 1'b0;
        digit       = 4'd0;
    endtask

    task automatic enter_code(input logic [15:0] code);
        logic [15:0] c;
        c = code;
        for (int i = 0; i < 4; i++) send_digit(c[15 - 4*i -: 4]);
        check("cnt4_in_check", 32'(digit_cnt), 32'd4);
    endtask

    // Queue an outcome whose outputs rise two edges after the last of ndig strobes.
    task automatic expect_result(input string tag, input bit open, input bit lock,
                                 input int unsigned dur, input logic [1:0] fail,
                                 input logic [1:0] fail_end, input int unsigned ndig);
        exp_t e;
        e.tag      = tag;
        e.open     = open;
        e.lock     = lock;
        e.dur      = dur;
        e.t_rise   = cyc + ndig + 2;
        e.fail     = fail;
        e.fail_end = fail_end;
        sb.push_back(e);
    endtask

    task automatic wait_outcome();
        exp_t        e;
        int          k;
        int          bad_cyc;
        k = 0;
        while (!(unlocked || error) && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("outcome_rise", 32'(unlocked || error), 32'd1);
        if (!(unlocked || error)) return;
        check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check({e.tag, "_lat"}, cyc, e.t_rise);
        check({e.tag, "_fail"}, 32'(fail_cnt), 32'(e.fail));
        bad_cyc = 0;
        for (int i = 0; i < int'(e.dur); i++) begin
            if (i > 0) @(negedge clk);
            if (unlocked !== e.open || error !== err_exp(e.open, i) || locked_out !== e.lock)
                bad_cyc++;
        end
        check({e.tag, "_window"}, 32'(bad_cyc), 32'd0);
        @(negedge clk);
        check({e.tag, "_end"}, 32'({unlocked, error, locked_out}), 32'd0);
        check({e.tag, "_fail_end"}, 32'(fail_cnt), 32'(e.fail_end));
    endtask

    task automatic wait_high(input string tag, input bit want_lock);
        int k;
        k = 0;
        while (!(want_lock ? locked_out : unlocked) && k < 10) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(want_lock ? locked_out : unlocked), 32'd1);
    endtask

    initial begin
        rst         = 1'b1;
        digit_valid = 1'b0;
        digit       = 4'd0;
        clear       = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_unlocked", 32'(unlocked), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_locked_out", 32'(locked_out), 32'd0);
        check("rst_digit_cnt", 32'(digit_cnt), 32'd0);
        check("rst_fail_cnt", 32'(fail_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        expect_result("open", 1'b1, 1'b0, 50, 2'd0, 2'd0, 4);
        enter_code(16'h1234);
        wait_outcome();

        expect_result("wrong1235", 1'b0, 1'b0, 20, 2'd1, 2'd1, 4);
        enter_code(16'h1235);
        wait_outcome();

        expect_result("digit_a", 1'b0, 1'b0, 20, 2'd2, 2'd2, 1);
        send_digit(4'hA);
        wait_outcome();

        expect_result("lockout", 1'b0, 1'b1, 200, 2'd3, 2'd0, 4);
        enter_code(16'h9999);
        fork
            wait_outcome();
            begin
                repeat (30) @(negedge clk);
                send_digit(4'd1);
                send_digit(4'd2);
                send_digit(4'd3);
                send_digit(4'd4);
                check("lock_ignores_digits", 32'(digit_cnt), 32'd0);
            end
        join
        check("lock_cnt_after", 32'(digit_cnt), 32'd0);

        send_digit(4'd1);
        send_digit(4'd2);
        check("partial_cnt", 32'(digit_cnt), 32'd2);
        clear       = 1'b1;
        digit_valid = 1'b1;
        digit       = 4'd3;
        @(negedge clk);
        clear       = 1'b0;
        digit_valid = 1'b0;
        digit       = 4'd0;
        check("clear_wins", 32'(digit_cnt), 32'd0);

        expect_result("open_after_clear", 1'b1, 1'b0, 50, 2'd0, 2'd0, 4);
        enter_code(16'h1234);
        wait_outcome();

        enter_code(16'h1234);
        wait_high("clr_open_up", 1'b0);
        repeat (5) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        check("clear_ends_open", 32'(unlocked), 32'd0);

        enter_code(16'h1234);
        wait_high("rst_open_up", 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_open", 32'({unlocked, error, locked_out, digit_cnt, fail_cnt}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        expect_result("w1", 1'b0, 1'b0, 20, 2'd1, 2'd1, 4);
        enter_code(16'h1111);
        wait_outcome();
        expect_result("w2", 1'b0, 1'b0, 20, 2'd2, 2'd2, 4);
        enter_code(16'h2222);
        wait_outcome();
        enter_code(16'h3333);
        wait_high("rst_lock_up", 1'b1);
        check("rst_lock_fail3", 32'(fail_cnt), 32'd3);
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_lockout", 32'({unlocked, error, locked_out, digit_cnt, fail_cnt}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
